// File: rtl/vm_pkg.sv
// Shared types and default constants for the two-product vending sale controller.
// Prices are in credit units; stock is a per-product item count.
package vm_pkg;

  typedef enum logic [1:0] {
    VM_IDLE     = 2'd0,
    VM_CREDIT   = 2'd1,
    VM_DISPENSE = 2'd2,
    VM_CHANGE   = 2'd3
  } vm_state_e;

  typedef enum logic {
    VM_COFFEE = 1'b0,
    VM_SPRITE = 1'b1
  } vm_prod_e;

  localparam int VM_COFFEE_PRICE     = 1;
  localparam int VM_SPRITE_PRICE     = 3;
  localparam int VM_MAX_CREDIT       = 3;
  localparam int VM_STOCK_MAX        = 7;
  localparam int VM_DISPENSE_CYCLES  = 4;

  // Round-robin helper: the product that was not served last.
  function automatic vm_prod_e vm_other(input vm_prod_e p);
    return (p == VM_COFFEE) ? VM_SPRITE : VM_COFFEE;
  endfunction

endpackage

// File: rtl/vm_sale_controller_if.sv
// Panel-side signal bundle of the sale controller: raw button/coin levels in,
// actuator, pulse, LED and credit outputs back.
interface vm_sale_controller_if #(
  parameter int CW = 2
);
  logic          i_coin;
  logic          i_coffee;
  logic          i_sprite;
  logic          i_cancel;
  logic          i_refill;
  logic          o_coffee;
  logic          o_sprite;
  logic          o_change;
  logic          o_coin_reject;
  logic          o_led_coffee;
  logic          o_led_sprite;
  logic          o_empty_coffee;
  logic          o_empty_sprite;
  logic [CW-1:0] o_credit;

  modport master (
    output i_coin, i_coffee, i_sprite, i_cancel, i_refill,
    input  o_coffee, o_sprite, o_change, o_coin_reject,
           o_led_coffee, o_led_sprite, o_empty_coffee, o_empty_sprite, o_credit
  );

  modport slave (
    input  i_coin, i_coffee, i_sprite, i_cancel, i_refill,
    output o_coffee, o_sprite, o_change, o_coin_reject,
           o_led_coffee, o_led_sprite, o_empty_coffee, o_empty_sprite, o_credit
  );
endinterface

// File: rtl/vm_rise_detect.sv
// Rising-edge detector over a bus of level inputs; combinational event, one register stage of history.
// History resets to all-ones so a level already high at reset release never counts as an event.
module vm_rise_detect #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lvl_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  assign prev_d = lvl_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/vm_sale_controller.sv
// Vending sale controller: owns credit, stock, round-robin arbitration, dispense timing and change return.
// Events act at the edge closing the cycle they are seen in; every output comes straight from registers.
module vm_sale_controller
  import vm_pkg::*;
#(
  parameter int COFFEE_PRICE    = VM_COFFEE_PRICE,
  parameter int SPRITE_PRICE    = VM_SPRITE_PRICE,
  parameter int MAX_CREDIT      = VM_MAX_CREDIT,
  parameter int STOCK_MAX       = VM_STOCK_MAX,
  parameter int DISPENSE_CYCLES = VM_DISPENSE_CYCLES
) (
  input logic                clk,
  input logic                rst,
  vm_sale_controller_if.slave bus
);

  localparam int CW = $clog2(MAX_CREDIT + 1);
  localparam int SW = $clog2(STOCK_MAX + 1);
  localparam int DW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  localparam logic [CW-1:0] COFFEE_P = CW'(COFFEE_PRICE);
  localparam logic [CW-1:0] SPRITE_P = CW'(SPRITE_PRICE);
  localparam logic [CW-1:0] CREDIT_M = CW'(MAX_CREDIT);
  localparam logic [SW-1:0] STOCK_M  = SW'(STOCK_MAX);
  localparam logic [DW-1:0] CNT_LOAD = DW'(DISPENSE_CYCLES - 1);

  logic [4:0] ev;
  logic       coin_ev, coffee_ev, sprite_ev, cancel_ev, refill_ev;

  vm_rise_detect #(.W(5)) u_rise (
    .clk    (clk),
    .rst    (rst),
    .lvl_i  ({bus.i_refill, bus.i_cancel, bus.i_sprite, bus.i_coffee, bus.i_coin}),
    .rise_o (ev)
  );

  assign coin_ev   = ev[0];
  assign coffee_ev = ev[1];
  assign sprite_ev = ev[2];
  assign cancel_ev = ev[3];
  assign refill_ev = ev[4];

  vm_state_e     state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [SW-1:0] stock_cof_q, stock_cof_d;
  logic [SW-1:0] stock_spr_q, stock_spr_d;
  vm_prod_e      last_q, last_d;
  vm_prod_e      prod_q, prod_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          change_q, change_d;
  logic          reject_q, reject_d;

  logic     open_st;
  logic     elig_cof, elig_spr;
  logic     req_cof, req_spr;
  logic     grant;
  vm_prod_e grant_prod;
  logic     coin_ok;

  // Eligibility looks only at registered state, so the LEDs have no input-to-output path.
  assign open_st  = (state_q == VM_IDLE) || (state_q == VM_CREDIT);
  assign elig_cof = open_st && (credit_q >= COFFEE_P) && (stock_cof_q != '0);
  assign elig_spr = open_st && (credit_q >= SPRITE_P) && (stock_spr_q != '0);

  assign req_cof    = coffee_ev && elig_cof;
  assign req_spr    = sprite_ev && elig_spr;
  assign grant      = req_cof || req_spr;
  assign grant_prod = (req_cof && req_spr) ? vm_other(last_q)
                    : (req_cof ? VM_COFFEE : VM_SPRITE);
  assign coin_ok    = coin_ev && open_st && (credit_q < CREDIT_M) && !grant;

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    stock_cof_d = stock_cof_q;
    stock_spr_d = stock_spr_q;
    last_d      = last_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    change_d    = 1'b0;
    reject_d    = coin_ev && !coin_ok;

    unique case (state_q)
      VM_IDLE, VM_CREDIT: begin
        if (coin_ok) begin
          credit_d = credit_q + CW'(1);
          state_d  = VM_CREDIT;
        end
        if (grant) begin
          state_d = VM_DISPENSE;
          prod_d  = grant_prod;
          last_d  = grant_prod;
          cnt_d   = CNT_LOAD;
          if (grant_prod == VM_COFFEE) begin
            credit_d    = credit_q - COFFEE_P;
            stock_cof_d = stock_cof_q - SW'(1);
          end else begin
            credit_d    = credit_q - SPRITE_P;
            stock_spr_d = stock_spr_q - SW'(1);
          end
        end else if (cancel_ev && (state_q == VM_CREDIT)) begin
          // First change pulse leaves with the transition; a coin accepted now is returned too.
          state_d  = VM_CHANGE;
          change_d = 1'b1;
          credit_d = credit_d - CW'(1);
        end else if (refill_ev && (state_q == VM_IDLE)) begin
          stock_cof_d = STOCK_M;
          stock_spr_d = STOCK_M;
        end
      end

      VM_DISPENSE: begin
        if (cnt_q == '0) begin
          state_d = (credit_q != '0) ? VM_CREDIT : VM_IDLE;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end

      VM_CHANGE: begin
        // Alternate pulse / gap cycles; leave once the final pulse has been shown.
        if (change_q) begin
          if (credit_q == '0) begin
            state_d = VM_IDLE;
          end
        end else begin
          change_d = 1'b1;
          credit_d = credit_q - CW'(1);
        end
      end

      default: state_d = VM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= VM_IDLE;
      credit_q    <= '0;
      stock_cof_q <= STOCK_M;
      stock_spr_q <= STOCK_M;
      last_q      <= VM_SPRITE;
      prod_q      <= VM_COFFEE;
      cnt_q       <= '0;
      change_q    <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      stock_cof_q <= stock_cof_d;
      stock_spr_q <= stock_spr_d;
      last_q      <= last_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      change_q    <= change_d;
      reject_q    <= reject_d;
    end
  end

  assign bus.o_coffee       = (state_q == VM_DISPENSE) && (prod_q == VM_COFFEE);
  assign bus.o_sprite       = (state_q == VM_DISPENSE) && (prod_q == VM_SPRITE);
  assign bus.o_change       = change_q;
  assign bus.o_coin_reject  = reject_q;
  assign bus.o_led_coffee   = elig_cof;
  assign bus.o_led_sprite   = elig_spr;
  assign bus.o_empty_coffee = (stock_cof_q == '0);
  assign bus.o_empty_sprite = (stock_spr_q == '0);
  assign bus.o_credit       = credit_q;

  a_credit_cap: assert property (@(posedge clk) disable iff (rst) credit_q <= CREDIT_M);
  a_one_actuator: assert property (@(posedge clk) disable iff (rst) !(bus.o_coffee && bus.o_sprite));
  a_stock_cap: assert property (@(posedge clk) disable iff (rst)
                                (stock_cof_q <= STOCK_M) && (stock_spr_q <= STOCK_M));

endmodule

// File: tb/tb_vm_sale_controller.sv
// Directed bench for vm_sale_controller: a cycle-level behavioural model scored every cycle,
// plus literal expectations at the key points of each scenario.
module tb_vm_sale_controller;
  import vm_pkg::*;

  localparam int CW   = 2;
  localparam int D    = 4;
  localparam int SMAX = 7;
  localparam int PC   = 1;
  localparam int PS   = 3;
  localparam int MAXC = 3;

  localparam logic [4:0] M_COIN = 5'b00001;
  localparam logic [4:0] M_COF  = 5'b00010;
  localparam logic [4:0] M_SPR  = 5'b00100;
  localparam logic [4:0] M_CAN  = 5'b01000;
  localparam logic [4:0] M_REF  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] tb_in = '0;

  always #5 clk = ~clk;

  vm_sale_controller_if #(.CW(CW)) bus ();
  assign {bus.i_refill, bus.i_cancel, bus.i_sprite, bus.i_coffee, bus.i_coin} = tb_in;

  vm_sale_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int price_of(input int p);
    return (p == 0) ? PC : PS;
  endfunction

  // Behavioural model: cycle numbers for busy windows, a list of change-pulse cycles.
  int         m_cyc = 0;
  bit         m_valid = 1'b0;
  int         m_credit, m_last, m_act, m_disp_end, m_busy_end;
  int         m_stock [2];
  int         m_pulses [$];
  bit         m_change, m_reject;
  logic [4:0] m_prev;
  int         mn, mg;
  bit         mfree;
  bit         mrq [2];
  logic [4:0] mev;

  always @(posedge clk) begin
    if (rst) begin
      m_valid    = 1'b1;
      m_credit   = 0;
      m_stock[0] = SMAX;
      m_stock[1] = SMAX;
      m_last     = 1;
      m_act      = 0;
      m_disp_end = -1;
      m_busy_end = -1;
      m_pulses.delete();
      m_change   = 1'b0;
      m_reject   = 1'b0;
      m_prev     = '1;
      m_cyc      = m_cyc + 1;
    end else if (m_valid) begin
      mev    = tb_in & ~m_prev;
      m_prev = tb_in;
      mn     = m_cyc;
      mfree  = (mn > m_busy_end);
      for (int p = 0; p < 2; p++)
        mrq[p] = mev[1+p] && mfree && (m_credit >= price_of(p)) && (m_stock[p] > 0);
      mg = -1;
      if (mrq[0] && mrq[1]) mg = 1 - m_last;
      else if (mrq[0])      mg = 0;
      else if (mrq[1])      mg = 1;
      m_reject = 1'b0;
      if (mg >= 0) begin
        m_credit   = m_credit - price_of(mg);
        m_stock[mg]--;
        m_last     = mg;
        m_act      = mg;
        m_disp_end = mn + D;
        m_busy_end = mn + D;
      end
      if (mev[4] && mg < 0 && mfree && m_credit == 0) begin
        m_stock[0] = SMAX;
        m_stock[1] = SMAX;
      end
      if (mev[3] && mg < 0 && mfree && m_credit > 0) begin
        if (mev[0] && m_credit < MAXC) m_credit++;
        else if (mev[0])               m_reject = 1'b1;
        for (int i = 0; i < m_credit; i++) m_pulses.push_back(mn + 1 + 2 * i);
        m_busy_end = mn + 2 * m_credit - 1;
      end else if (mev[0]) begin
        if (mfree && m_credit < MAXC && mg < 0) m_credit++;
        else                                   m_reject = 1'b1;
      end
      m_cyc    = mn + 1;
      m_change = 1'b0;
      if (m_pulses.size() > 0 && m_pulses[0] == m_cyc) begin
        void'(m_pulses.pop_front());
        m_credit--;
        m_change = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("credit",      int'(bus.o_credit),       m_credit);
      chk("o_coffee",    int'(bus.o_coffee),       int'(m_cyc <= m_disp_end && m_act == 0));
      chk("o_sprite",    int'(bus.o_sprite),       int'(m_cyc <= m_disp_end && m_act == 1));
      chk("o_change",    int'(bus.o_change),       int'(m_change));
      chk("coin_reject", int'(bus.o_coin_reject),  int'(m_reject));
      chk("led_coffee",  int'(bus.o_led_coffee),
          int'(m_cyc > m_busy_end && m_credit >= PC && m_stock[0] > 0));
      chk("led_sprite",  int'(bus.o_led_sprite),
          int'(m_cyc > m_busy_end && m_credit >= PS && m_stock[1] > 0));
      chk("empty_coffee", int'(bus.o_empty_coffee), int'(m_stock[0] == 0));
      chk("empty_sprite", int'(bus.o_empty_sprite), int'(m_stock[1] == 0));
    end
  end

  // Running activity counters, sampled just after each active edge.
  int cnt_cof = 0, cnt_spr = 0, cnt_chg = 0, cnt_rej = 0;
  always @(posedge clk) begin
    #1;
    if (bus.o_coffee)      cnt_cof++;
    if (bus.o_sprite)      cnt_spr++;
    if (bus.o_change)      cnt_chg++;
    if (bus.o_coin_reject) cnt_rej++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    tb_in = m;
    @(negedge clk);
    tb_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    tb_in = '0;
    cyc(2);
    rst = 1'b0;
  endtask

  int s_cof, s_spr, s_chg, s_rej;

  initial begin
    cyc(3);
    rst = 1'b0;
    chk("reset credit",     int'(bus.o_credit), 0);
    chk("reset led_coffee", int'(bus.o_led_coffee), 0);
    chk("reset empty",      int'(bus.o_empty_coffee), 0);
    chk("reset state",      int'(dut.state_q), int'(VM_IDLE));
    chk("reset stock",      int'(dut.stock_cof_q), 7);

    // Single coffee
    press(M_COIN);
    chk("t1 credit after coin", int'(bus.o_credit), 1);
    s_cof = cnt_cof; s_chg = cnt_chg;
    press(M_COF);
    cyc(6);
    chk("t1 coffee cycles", cnt_cof - s_cof, 4);
    chk("t1 credit",        int'(bus.o_credit), 0);
    chk("t1 stock coffee",  int'(dut.stock_cof_q), 6);
    chk("t1 state",         int'(dut.state_q), int'(VM_IDLE));
    chk("t1 no change",     cnt_chg - s_chg, 0);

    // Simultaneous buttons, round-robin
    do_reset();
    repeat (3) press(M_COIN);
    chk("t2 credit 3", int'(bus.o_credit), 3);
    s_cof = cnt_cof; s_spr = cnt_spr;
    press(M_COF | M_SPR);
    cyc(6);
    chk("t2 first is coffee", cnt_cof - s_cof, 4);
    chk("t2 first no sprite", cnt_spr - s_spr, 0);
    chk("t2 credit 2",        int'(bus.o_credit), 2);
    press(M_COIN);
    s_cof = cnt_cof; s_spr = cnt_spr;
    press(M_COF | M_SPR);
    cyc(6);
    chk("t2 second is sprite", cnt_spr - s_spr, 4);
    chk("t2 second no coffee", cnt_cof - s_cof, 0);
    chk("t2 credit 0",         int'(bus.o_credit), 0);
    chk("t2 stock sprite",     int'(dut.stock_spr_q), 6);

    // Credit cap and coin while busy
    do_reset();
    s_rej = cnt_rej;
    repeat (4) press(M_COIN);
    chk("t3 credit capped", int'(bus.o_credit), 3);
    chk("t3 one reject",    cnt_rej - s_rej, 1);
    s_rej = cnt_rej;
    press(M_COF);
    press(M_COIN);
    cyc(4);
    chk("t3 busy reject",   cnt_rej - s_rej, 1);
    chk("t3 credit kept",   int'(bus.o_credit), 2);

    // Cancel with credit 2
    press(M_CAN);
    chk("t4 change n+1",  int'(bus.o_change), 1);
    cyc(1);
    chk("t4 gap n+2",     int'(bus.o_change), 0);
    cyc(1);
    chk("t4 change n+3",  int'(bus.o_change), 1);
    chk("t4 credit 0",    int'(bus.o_credit), 0);
    cyc(1);
    chk("t4 idle n+4",    int'(dut.state_q), int'(VM_IDLE));
    press(M_COIN);
    press(M_COIN);
    s_cof = cnt_cof; s_chg = cnt_chg;
    press(M_CAN | M_COF);
    cyc(6);
    chk("t4 grant beats cancel", cnt_cof - s_cof, 4);
    chk("t4 no change",          cnt_chg - s_chg, 0);
    chk("t4 credit left",        int'(bus.o_credit), 1);
    press(M_CAN);
    cyc(3);

    // Stock exhaustion and refill
    do_reset();
    repeat (7) begin
      press(M_COIN);
      press(M_COF);
      cyc(5);
    end
    chk("t5 empty coffee", int'(bus.o_empty_coffee), 1);
    chk("t5 led off",      int'(bus.o_led_coffee), 0);
    press(M_COIN);
    s_cof = cnt_cof;
    press(M_COF);
    cyc(5);
    chk("t5 no dispense",  cnt_cof - s_cof, 0);
    chk("t5 credit kept",  int'(bus.o_credit), 1);
    press(M_REF);
    cyc(1);
    chk("t5 refill ignored in credit", int'(dut.stock_cof_q), 0);
    press(M_CAN);
    cyc(3);
    press(M_REF);
    chk("t5 refill coffee", int'(dut.stock_cof_q), 7);
    chk("t5 refill sprite", int'(dut.stock_spr_q), 7);
    chk("t5 not empty",     int'(bus.o_empty_coffee), 0);

    // Reset in dispense cycle 2, button held across release
    do_reset();
    press(M_COIN);
    @(negedge clk);
    tb_in = M_COF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 coffee off", int'(bus.o_coffee), 0);
    chk("t6 credit lost", int'(bus.o_credit), 0);
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    tb_in = M_COF | M_COIN;
    @(negedge clk);
    tb_in = M_COF;
    s_cof = cnt_cof;
    cyc(6);
    chk("t6 held button ignored", cnt_cof - s_cof, 0);
    chk("t6 credit 1",            int'(bus.o_credit), 1);
    tb_in = '0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
